// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture sequencing controller.
// Imported by the sequencer top and its testbench-facing logic.
package gesture_pkg;

    localparam int GESTURE_W = 4;

    localparam logic [GESTURE_W-1:0] GESTURE_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus per-bit stability counter.
// A bit is accepted once it has differed from the clean value for DB_CYCLES.
module sensor_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 500_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] clean_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Per bit: restart while in agreement, accept after a full stable run.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
            if (sync_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                clean_d[i] = sync_q[i];
                cnt_d[i]   = '0;
            end
        end
    end

    // Synchroniser, clean value and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= '0;
            sync_q  <= '0;
            clean_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/gesture_sequencer.sv
// Sequences the gesture FSM: sample enables while a gesture is in progress,
// holds each recognised code for the display, then clears the FSM.
module gesture_sequencer
    import gesture_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DB_CYCLES  = 500_000,
    parameter int HOLD_TICKS = 3,
    parameter int IDLE_TICKS = 2
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n,
    input  logic [GESTURE_W-1:0] sw,
    input  logic [GESTURE_W-1:0] gesture_code,
    output logic [GESTURE_W-1:0] sensor_clean,
    output logic                 sample_en,
    output logic                 fsm_clr,
    output logic [GESTURE_W-1:0] disp_code,
    output logic                 disp_valid
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int IW = $clog2(IDLE_TICKS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TICKS);

    seq_state_t           state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [IW-1:0]        idle_q, idle_d;
    logic                 sample_q, sample_d;
    logic                 clr_q, clr_d;
    logic                 look_q, look_d;
    logic [GESTURE_W-1:0] code_q, code_d;
    logic                 valid_q, valid_d;
    logic                 tick;
    logic                 any_sensor;

    sensor_debounce #(
        .WIDTH     (GESTURE_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk_i   (clk_50mhz),
        .rst_ni  (rst_n),
        .raw_i   (sw),
        .clean_o (sensor_clean)
    );

    assign tick       = (presc_q == PRESC_MAX);
    assign any_sensor = (sensor_clean != '0);

    // Next state, counters and registered strobes/display outputs.
    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        hold_d   = hold_q;
        idle_d   = idle_q;
        sample_d = 1'b0;
        clr_d    = 1'b0;
        look_d   = sample_q;
        code_d   = code_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                hold_d  = '0;
                idle_d  = '0;
                if (any_sensor) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (look_q && gesture_code != GESTURE_NONE) begin
                    state_d = HOLD;
                    code_d  = gesture_code;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    idle_d  = '0;
                end else if (tick) begin
                    if (any_sensor) begin
                        idle_d   = '0;
                        sample_d = 1'b1;
                    end else if (idle_q + IW'(1) == IDLE_MAX) begin
                        idle_d  = '0;
                        clr_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idle_d   = idle_q + IW'(1);
                        sample_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_q + HW'(1) == HOLD_MAX) begin
                        hold_d  = '0;
                        clr_d   = 1'b1;
                        valid_d = 1'b0;
                        code_d  = GESTURE_NONE;
                        state_d = any_sensor ? ACTIVE : IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the display immediately.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            hold_q   <= '0;
            idle_q   <= '0;
            sample_q <= 1'b0;
            clr_q    <= 1'b0;
            look_q   <= 1'b0;
            code_q   <= GESTURE_NONE;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            idle_q   <= idle_d;
            sample_q <= sample_d;
            clr_q    <= clr_d;
            look_q   <= look_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_en  = sample_q;
    assign fsm_clr    = clr_q;
    assign disp_code  = code_q;
    assign disp_valid = valid_q;

endmodule

// File: tb/tb_gesture_sequencer.sv
// Directed bench for gesture_sequencer with a tiny gesture FSM model.
// Timing expectations are hand-derived for TICK_DIV=8, DB_CYCLES=4.
module tb_gesture_sequencer;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] sw        = 4'hF;
    logic [3:0] gesture_code;
    logic [3:0] sensor_clean;
    logic       sample_en;
    logic       fsm_clr;
    logic [3:0] disp_code;
    logic       disp_valid;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int se_cnt;
    int se_seen  = 0;
    int clr_seen = 0;
    int both_seen = 0;
    int se_mark;
    int clr_mark;

    gesture_sequencer #(
        .TICK_DIV   (8),
        .DB_CYCLES  (4),
        .HOLD_TICKS (2),
        .IDLE_TICKS (3)
    ) dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .sw           (sw),
        .gesture_code (gesture_code),
        .sensor_clean (sensor_clean),
        .sample_en    (sample_en),
        .fsm_clr      (fsm_clr),
        .disp_code    (disp_code),
        .disp_valid   (disp_valid)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    // Gesture FSM model: mode 1 reports 4'hA on the third enable,
    // mode 2 on every enable, mode 0 never.
    always @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            gesture_code <= 4'h0;
            se_cnt       <= 0;
        end else if (fsm_clr) begin
            gesture_code <= 4'h0;
        end else if (sample_en) begin
            if (mode == 1) se_cnt <= se_cnt + 1;
            gesture_code <= ((mode == 1 && se_cnt == 2) || mode == 2)
                            ? 4'hA : 4'h0;
        end
    end

    // Pulse counters, tallied at each edge from the pre-edge values.
    always @(posedge clk_50mhz) begin
        if (sample_en) se_seen++;
        if (fsm_clr) clr_seen++;
        if (sample_en && fsm_clr) both_seen++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    initial begin
        // Reset with all sensors asserted.
        cyc(3);
        chk("rst_clean", sensor_clean, 0);
        chk("rst_se", sample_en, 0);
        chk("rst_clr", fsm_clr, 0);
        chk("rst_code", disp_code, 0);
        chk("rst_valid", disp_valid, 0);
        se_mark = se_seen;
        rst_n = 1'b1;
        cyc(6);
        chk("rst_db_early", sensor_clean, 0);
        cyc(1);
        chk("rst_db_done", sensor_clean, 4'hF);
        chk("rst_no_se", se_seen - se_mark, 0);
        cyc(8);
        chk("rst_se_t15", sample_en, 0);
        cyc(1);
        chk("rst_se_t16", sample_en, 1);

        // Reset again with sensors clear, then bounce sw[0].
        rst_n = 1'b0;
        sw = 4'h0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        chk("rst2_clean", sensor_clean, 0);
        se_mark = se_seen;
        for (int i = 0; i < 10; i++) begin
            sw[0] = ~sw[0];
            cyc(2);
            chk("bounce_clean", sensor_clean, 0);
        end
        chk("bounce_no_se", se_seen - se_mark, 0);

        // Final edge to 1: accepted exactly 7 cycles later.
        sw = 4'h1;
        cyc(6);
        chk("db_t6", sensor_clean, 0);
        cyc(1);
        chk("db_t7", sensor_clean, 4'h1);

        // Sampling with gesture on the third enable.
        sw = 4'h3;
        mode = 1;
        cyc(8);
        chk("se_t15", sample_en, 0);
        cyc(1);
        chk("se_t16", sample_en, 1);
        chk("clr_t16", fsm_clr, 0);
        cyc(7);
        chk("se_t23", sample_en, 0);
        cyc(1);
        chk("se_t24", sample_en, 1);
        cyc(8);
        chk("se_t32", sample_en, 1);
        cyc(1);
        chk("valid_t33", disp_valid, 0);
        cyc(1);
        chk("valid_t34", disp_valid, 1);
        chk("code_t34", disp_code, 4'hA);
        se_mark  = se_seen;
        clr_mark = clr_seen;
        cyc(13);
        chk("hold_valid", disp_valid, 1);
        chk("hold_code", disp_code, 4'hA);
        chk("hold_no_se", se_seen - se_mark, 0);
        chk("hold_no_clr", clr_seen - clr_mark, 0);
        cyc(1);
        chk("hold_end_clr", fsm_clr, 1);
        chk("hold_end_se", sample_en, 0);
        chk("hold_end_valid", disp_valid, 0);
        chk("hold_end_code", disp_code, 0);
        cyc(1);
        chk("hold_clr_once", fsm_clr, 0);

        // Release sensors: three clear ticks then back to idle.
        sw = 4'h0;
        cyc(7);
        chk("act_se_t56", sample_en, 1);
        chk("act_code", disp_code, 0);
        cyc(8);
        chk("idle_se_t64", sample_en, 1);
        cyc(8);
        chk("idle_se_t72", sample_en, 1);
        cyc(8);
        chk("idle_clr_t80", fsm_clr, 1);
        chk("idle_se_t80", sample_en, 0);
        cyc(1);
        chk("idle_clr_t81", fsm_clr, 0);
        se_mark  = se_seen;
        clr_mark = clr_seen;
        cyc(30);
        chk("idle_no_se", se_seen - se_mark, 0);
        chk("idle_no_clr", clr_seen - clr_mark, 0);

        // Enter HOLD again, then reset asynchronously mid-hold.
        sw = 4'h3;
        mode = 2;
        cyc(17);
        chk("h2_valid_t17", disp_valid, 0);
        cyc(1);
        chk("h2_valid_t18", disp_valid, 1);
        chk("h2_code_t18", disp_code, 4'hA);
        clr_mark = clr_seen;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", disp_valid, 0);
        chk("async_code", disp_code, 0);
        chk("async_clr", fsm_clr, 0);
        cyc(3);
        chk("async_no_clr", clr_seen - clr_mark, 0);
        chk("async_hold_valid", disp_valid, 0);
        chk("never_both", both_seen, 0);
        rst_n = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
